// File: rtl/instr_stream_loader.sv
// rtl/instr_stream_loader.sv - byte-stream program loader for the instruction memory write port (optional INSTR_LOADER_CHECKSUM_EN)
module instr_stream_loader #(
    parameter int WR_BYTES   = 4,
    parameter int LOG_WR_WIN = 2,
    parameter int MAX_LEN    = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load_start,
    input  logic [7:0]              i_byte,
    input  logic                    i_byte_vld,
    output logic                    o_byte_rdy,
    output logic                    o_wr_vld,
    output logic [8*WR_BYTES-1:0]   o_wr_data,
    output logic [LOG_WR_WIN-1:0]   o_wr_shift_minusone,
    input  logic                    i_wr_rdy,
    output logic                    o_cpu_rst_n,
    output logic                    o_load_done,
    output logic                    o_load_error
);

    localparam int FW = LOG_WR_WIN + 1;
    localparam int DW = 8 * WR_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WAIT,
        S_DONE,
        S_ERR
`ifdef INSTR_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           len_q, len_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic [31:0]           rem_q, rem_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [DW-1:0]         pack_q, pack_d;
    logic                  wr_vld_q, wr_vld_d;
    logic [DW-1:0]         wr_data_q, wr_data_d;
    logic [LOG_WR_WIN-1:0] wr_smo_q, wr_smo_d;
    logic                  done_q, done_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  err_q, err_d;
    logic                  byte_rdy;
    logic                  go;
    logic [DW-1:0]         pack_n;
    logic [FW-1:0]         fill_n;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hdr_cnt_d   = hdr_cnt_q;
        rem_d       = rem_q;
        fill_d      = fill_q;
        pack_d      = pack_q;
        wr_vld_d    = wr_vld_q;
        wr_data_d   = wr_data_q;
        wr_smo_d    = wr_smo_q;
        err_d       = err_q;
        byte_rdy    = 1'b0;
        go          = 1'b0;
        pack_n      = pack_q;
        fill_n      = fill_q + FW'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        for (int l = 0; l < WR_BYTES; l++) begin
            if (fill_q == FW'(l)) pack_n[8*l +: 8] = i_byte;
        end

        case (state_q)
            S_IDLE: go = i_load_start;
            S_HDR: begin
                byte_rdy = 1'b1;
                if (i_byte_vld) begin
                    // Length arrives LSB first, so shift each byte in from the top.
                    len_d     = {i_byte, len_q[31:8]};
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        if (len_d == 32'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end else if (len_d > 32'(MAX_LEN)) begin
                            state_d = S_ERR;
                        end else begin
                            rem_d   = len_d;
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                byte_rdy = 1'b1;
                if (i_byte_vld) begin
                    rem_d = rem_q - 32'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ i_byte;
`endif
                    if (fill_n == FW'(WR_BYTES) || rem_q == 32'd1) begin
                        wr_vld_d  = 1'b1;
                        wr_data_d = pack_n;
                        wr_smo_d  = fill_q[LOG_WR_WIN-1:0];
                        fill_d    = '0;
                        pack_d    = '0;
                        state_d   = S_WAIT;
                    end else begin
                        fill_d = fill_n;
                        pack_d = pack_n;
                    end
                end
            end
            S_WAIT: begin
                if (i_wr_rdy) begin
                    wr_vld_d = 1'b0;
                    if (rem_q != 32'd0) begin
                        state_d = S_DATA;
                    end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_DONE: go = i_load_start;
            S_ERR:  go = i_load_start;
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CSUM: begin
                byte_rdy = 1'b1;
                if (i_byte_vld) state_d = (i_byte == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (go) begin
            state_d   = S_HDR;
            err_d     = 1'b0;
            len_d     = '0;
            hdr_cnt_d = '0;
            rem_d     = '0;
            fill_d    = '0;
            pack_d    = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_d    = '0;
`endif
        end
        if (state_d == S_ERR) err_d = 1'b1;

        // Done and CPU release are registered copies of "next state is DONE".
        done_d      = (state_d == S_DONE);
        cpu_rst_n_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            hdr_cnt_q   <= '0;
            rem_q       <= '0;
            fill_q      <= '0;
            pack_q      <= '0;
            wr_vld_q    <= 1'b0;
            wr_data_q   <= '0;
            wr_smo_q    <= '0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hdr_cnt_q   <= hdr_cnt_d;
            rem_q       <= rem_d;
            fill_q      <= fill_d;
            pack_q      <= pack_d;
            wr_vld_q    <= wr_vld_d;
            wr_data_q   <= wr_data_d;
            wr_smo_q    <= wr_smo_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            err_q       <= err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign o_byte_rdy          = byte_rdy;
    assign o_wr_vld            = wr_vld_q;
    assign o_wr_data           = wr_data_q;
    assign o_wr_shift_minusone = wr_smo_q;
    assign o_cpu_rst_n         = cpu_rst_n_q;
    assign o_load_done         = done_q;
    assign o_load_error        = err_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// tb/tb_instr_stream_loader.sv - self-checking bench for instr_stream_loader
module tb_instr_stream_loader;

    localparam int MAXL = 4096;

    typedef logic [7:0] u8_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_load_start;
    logic [7:0]  i_byte;
    logic        i_byte_vld;
    logic        o_byte_rdy;
    logic        o_wr_vld;
    logic [31:0] o_wr_data;
    logic [1:0]  o_wr_shift_minusone;
    logic        i_wr_rdy;
    logic        o_cpu_rst_n;
    logic        o_load_done;
    logic        o_load_error;

    instr_stream_loader dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_load_start        (i_load_start),
        .i_byte              (i_byte),
        .i_byte_vld          (i_byte_vld),
        .o_byte_rdy          (o_byte_rdy),
        .o_wr_vld            (o_wr_vld),
        .o_wr_data           (o_wr_data),
        .o_wr_shift_minusone (o_wr_shift_minusone),
        .i_wr_rdy            (i_wr_rdy),
        .o_cpu_rst_n         (o_cpu_rst_n),
        .o_load_done         (o_load_done),
        .o_load_error        (o_load_error)
    );

    always #5 i_clk = ~i_clk;

    int          vectors = 0;
    int          miscompares = 0;
    u8_t         stream_q[$];
    logic [31:0] exp_data_q[$];
    logic [1:0]  exp_smo_q[$];
    int          wr_count = 0;
    int          stall_budget = 0;
    int          stall_seen = 0;
    bit          mon_en = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic [1:0]  prev_smo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: header LE, then program bytes chunked into 4-byte little-endian words.
    task automatic prepare(input int len, input logic [63:0] bytes_le);
        u8_t x;
        stream_q.delete();
        exp_data_q.delete();
        exp_smo_q.delete();
        x = 8'h00;
        for (int k = 0; k < 4; k++) stream_q.push_back(u8_t'(len >> (8 * k)));
        if (len <= MAXL) begin
            for (int i = 0; i < len; i++) begin
                stream_q.push_back(bytes_le[8*i +: 8]);
                x = x ^ bytes_le[8*i +: 8];
            end
            for (int i = 0; i < len; i += 4) begin
                int n;
                logic [31:0] w;
                n = (len - i < 4) ? len - i : 4;
                w = '0;
                for (int j = 0; j < n; j++) w[8*j +: 8] = bytes_le[8*(i+j) +: 8];
                exp_data_q.push_back(w);
                exp_smo_q.push_back(2'(n - 1));
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            stream_q.push_back(x);
`endif
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_rdy"},  o_byte_rdy, 0);
        check({tag, "_wr_vld"},    o_wr_vld, 0);
        check({tag, "_wr_data"},   o_wr_data, 0);
        check({tag, "_smo"},       o_wr_shift_minusone, 0);
        check({tag, "_cpu_rst_n"}, o_cpu_rst_n, 0);
        check({tag, "_done"},      o_load_done, 0);
        check({tag, "_error"},     o_load_error, 0);
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_load_start = 1'b1;
        @(negedge i_clk);
        i_load_start = 1'b0;
        #1;
        check("start_clears_done", o_load_done, 0);
        check("start_clears_err", o_load_error, 0);
        check("start_cpu_rst", o_cpu_rst_n, 0);
    endtask

    task automatic feed(input int n);
        int  sent;
        int  cyc;
        bit  acc;
        sent = 0;
        cyc = 0;
        while (sent < n && stream_q.size() > 0 && cyc < 2000) begin
            @(negedge i_clk);
            i_byte = stream_q[0];
            i_byte_vld = 1'b1;
            #1;
            acc = o_byte_rdy;
            @(posedge i_clk);
            if (acc) begin
                void'(stream_q.pop_front());
                sent++;
            end
            cyc++;
        end
        @(negedge i_clk);
        i_byte_vld = 1'b0;
        check("feed_timeout", cyc >= 2000, 0);
    endtask

    task automatic run_load(input bit exp_err, input int exp_wr);
        int c;
        wr_count = 0;
        pulse_start();
        feed(1000);
        c = 0;
        while (!(o_load_done || o_load_error) && c < 3000) begin
            @(negedge i_clk);
            #3;
            c++;
        end
        check("end_timeout", c >= 3000, 0);
        check("end_done", o_load_done, !exp_err);
        check("end_error", o_load_error, exp_err);
        check("end_cpu_rst_n", o_cpu_rst_n, !exp_err);
        check("end_byte_rdy", o_byte_rdy, 0);
        check("end_wr_count", wr_count, exp_wr);
        check("end_exp_left", exp_data_q.size(), 0);
    endtask

    initial begin
        i_wr_rdy = 1'b1;
        forever begin
            @(negedge i_clk);
            if (stall_budget > 0 && o_wr_vld) begin
                i_wr_rdy = 1'b0;
                stall_budget--;
            end else begin
                i_wr_rdy = 1'b1;
            end
        end
    end

    // Per-cycle compare of the write port against the model's word queue.
    always @(negedge i_clk) begin
        #2;
        if (mon_en) begin
            if (prev_stall) begin
                stall_seen++;
                check("stall_vld", o_wr_vld, 1);
                check("stall_data", o_wr_data, prev_data);
                check("stall_smo", o_wr_shift_minusone, prev_smo);
                check("stall_byte_rdy", o_byte_rdy, 0);
            end
            if (o_wr_vld && i_wr_rdy) begin
                wr_count++;
                if (exp_data_q.size() == 0) begin
                    check("unexpected_write", o_wr_data, 32'hxxxxxxxx);
                end else begin
                    check("wr_data", o_wr_data, exp_data_q.pop_front());
                    check("wr_smo", o_wr_shift_minusone, exp_smo_q.pop_front());
                end
            end
            if (o_wr_vld) check("byte_rdy_while_wr", o_byte_rdy, 0);
            prev_stall = o_wr_vld && !i_wr_rdy;
            prev_data  = o_wr_data;
            prev_smo   = o_wr_shift_minusone;
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_load_start = 1'b0;
        i_byte = 8'h00;
        i_byte_vld = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        check_reset_vals("reset");
        i_rst_n = 1'b1;
        mon_en = 1;

        prepare(8, 64'h000B1A6A_03410541);
        check("model_t1_w0", exp_data_q[0], 32'h03410541);
        check("model_t1_w1", exp_data_q[1], 32'h000B1A6A);
        check("model_t1_smo1", exp_smo_q[1], 2'd3);
        run_load(0, 2);

        prepare(5, 64'h00000055_44332211);
        check("model_t2_w0", exp_data_q[0], 32'h44332211);
        check("model_t2_w1", exp_data_q[1], 32'h00000055);
        check("model_t2_smo1", exp_smo_q[1], 2'd0);
        run_load(0, 2);

        prepare(4, 64'h00000000_DDCCBBAA);
        stall_budget = 10;
        stall_seen = 0;
        run_load(0, 1);
        check("stall_cycles", stall_seen, 10);

        prepare(65536, 64'h0);
        check("model_err_stream_len", stream_q.size(), 4);
        run_load(1, 0);
        prepare(5, 64'h00000055_44332211);
        run_load(0, 2);

        prepare(8, 64'h8877665544332211);
        wr_count = 0;
        pulse_start();
        feed(6);
        @(negedge i_clk);
        mon_en = 0;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        check_reset_vals("midload_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check_reset_vals("after_reset");
        check("midload_wr_count", wr_count, 0);
        exp_data_q.delete();
        exp_smo_q.delete();
        mon_en = 1;

        prepare(0, 64'h0);
        check("model_len0_words", exp_data_q.size(), 0);
        run_load(0, 0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        prepare(2, 64'h0FA5);
        check("model_csum", stream_q[stream_q.size()-1], 8'hAA);
        check("model_csum_w0", exp_data_q[0], 32'h00000FA5);
        run_load(0, 1);
        prepare(2, 64'h0FA5);
        stream_q[stream_q.size()-1] = 8'hAB;
        run_load(1, 1);
`endif

        repeat (2) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
- Upstream feeder for the instruction memory write port. Today that port is tied off with the write request held at 0.
- Accepts a byte stream with a valid/ready handshake and parses a 4-byte little-endian length header. It then packs the program bytes into write-window words and drives the instruction memory write port: request, data, and shift_minusone.
- Holds the CPU core in reset until the whole program is written. A new load is started with a start pulse.

Parameters:
- WR_BYTES, 4, bytes per write word; must equal instr_write_width/8.
- LOG_WR_WIN, 2, width of o_wr_shift_minusone; equals log2(WR_BYTES).
- MAX_LEN, 4096, largest accepted program length in bytes. A larger header is an error.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset; sampled on the i_clk rising edge
- i_load_start  in  1  one-cycle pulse; starts a load from IDLE or DONE, ignored elsewhere
- i_byte  in  8  stream byte
- i_byte_vld  in  1  stream byte valid
- o_byte_rdy  out  1  loader accepts i_byte this cycle
- o_wr_vld  out  1  write request to the instruction memory controller
- o_wr_data  out  8*WR_BYTES  packed bytes; the first stream byte is in bits [7:0]
- o_wr_shift_minusone  out  LOG_WR_WIN  (valid byte count in o_wr_data) - 1
- i_wr_rdy  in  1  memory accepts the write this cycle
- o_cpu_rst_n  out  1  CPU core reset, active low
- o_load_done  out  1  high in DONE
- o_load_error  out  1  sticky error flag; cleared by reset or i_load_start

Behaviour:
- Reset values: o_byte_rdy=0, o_wr_vld=0, o_wr_data=0, o_wr_shift_minusone=0, o_cpu_rst_n=0, o_load_done=0, o_load_error=0. FSM goes to IDLE; all counters clear.
- A reset asserted mid-load aborts the load. Partially written memory contents are not rolled back.
- A byte transfer happens when i_byte_vld & o_byte_rdy.
- A word transfer happens when o_wr_vld & i_wr_rdy.
- FSM states:
  - IDLE: o_cpu_rst_n=0. On i_load_start go to HDR and clear the error flag.
  - HDR: o_byte_rdy=1. Accepts 4 bytes into a 32-bit length register, LSB first. After the 4th byte:
    - length=0 -> DONE, with no writes.
    - length>MAX_LEN -> ERR.
    - otherwise -> DATA, with remaining=length.
  - DATA: o_byte_rdy=1 only when no word is pending.
    - Each accepted byte is placed at byte lane fill_cnt; fill_cnt increments and remaining decrements.
    - When fill_cnt reaches WR_BYTES, or remaining reaches 0, the packed word is registered on the next edge. At that edge: o_wr_vld=1, o_wr_shift_minusone=fill_cnt-1, fill_cnt clears, and the FSM goes to WAIT.
    - Unused upper lanes of a partial word are 0.
  - WAIT: o_byte_rdy=0. o_wr_vld, o_wr_data and o_wr_shift_minusone are held stable until i_wr_rdy.
    - On the word transfer, o_wr_vld drops in the same edge.
    - Next state is DATA if remaining>0, else DONE.
    - Byte-to-write latency: 1 cycle from the last byte of a word to o_wr_vld.
  - DONE: o_load_done=1 and o_cpu_rst_n=1 (registered, asserted on the first DONE cycle). i_load_start goes to HDR, drops o_cpu_rst_n and clears o_load_done on the same edge.
  - ERR: o_load_error=1, o_cpu_rst_n=0, o_byte_rdy=0. Only i_load_start (-> HDR) or reset leaves ERR.
- Bytes presented in IDLE, WAIT, DONE or ERR are not accepted, because o_byte_rdy=0.
- i_load_start in HDR, DATA or WAIT is ignored.
- Throughput: at most WR_BYTES bytes per WR_BYTES+1 cycles when i_wr_rdy is held high. Stalling i_wr_rdy back-pressures the byte stream with no byte loss.
- The remaining counter is 32-bit, compares against 0 only, and never underflows.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- When defined:
  - After the last program byte, the FSM enters CSUM (o_byte_rdy=1) and accepts one extra byte.
  - The expected value is the XOR of all program bytes, header excluded. The running XOR register is cleared in HDR.
  - The final partial or full word is still written before CSUM.
  - Match -> DONE. Mismatch -> ERR.
  - For length=0 the checksum byte is still consumed and must equal 0x00.
- When undefined: no CSUM state, no XOR register, and the stream ends after the program bytes.

Test Plan:
- Reset, then start. Stream 08 00 00 00, 41 05 41 03 6A 1A 0B 00 with i_wr_rdy=1 -> two writes: data 0x03410541 smo=3, then 0x000B1A6A smo=3. o_cpu_rst_n rises after the 2nd write; o_load_done=1.
- Length 5, bytes 11 22 33 44 55 -> writes 0x44332211 smo=3, then 0x00000055 smo=0; DONE.
- Length 4, with i_wr_rdy held low 10 cycles after o_wr_vld -> o_wr_vld, o_wr_data and o_wr_shift_minusone stable all 10 cycles, o_byte_rdy=0, and one write occurs on release.
- Header 00 00 01 00 (65536 > MAX_LEN) -> ERR: o_load_error=1, no write, o_cpu_rst_n=0. A following start clears the error and loads a valid program.
- Reset asserted during DATA after 2 of 8 bytes -> all outputs at reset values next cycle, FSM in IDLE. With length 0 the loader goes straight to DONE with no o_wr_vld pulse.
- (INSTR_LOADER_CHECKSUM_EN) Length 2, bytes A5 0F, checksum AA -> DONE. The same stream with checksum AB -> ERR with o_load_error=1, after the single write 0x00000FA5 smo=1.
